// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DSP/TDM receive channel.
package i2s_pkg;

  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    OFFSET  = 2'd2,
    RUN     = 2'd3
  } i2s_state_e;

endpackage

// File: rtl/i2s_rx_dsp_channel_if.sv
// Word stream from the receive channel into the uDMA RX FIFO.
interface i2s_rx_dsp_channel_if;
  import i2s_pkg::*;

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_data_valid;
  logic              fifo_data_ready;
  logic              fifo_err;

  modport master (output fifo_data, output fifo_data_valid, output fifo_err,
                  input  fifo_data_ready);
  modport slave  (input  fifo_data, input  fifo_data_valid, input  fifo_err,
                  output fifo_data_ready);
endinterface

// File: rtl/i2s_rx_word_buffer.sv
// Two-entry holding FIFO with a dual-push port. The caller only pushes as
// many words as free_cnt (plus a same-cycle pop) allows.
module i2s_rx_word_buffer
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [1:0]        push_cnt,
  input  logic [DATA_W-1:0] push_data0,
  input  logic [DATA_W-1:0] push_data1,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [1:0]        free_cnt
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              rd_ptr;
  logic [1:0]        count;
  logic              wr_ptr;
  logic              do_pop;

  assign do_pop   = pop && valid;
  assign wr_ptr   = rd_ptr ^ count[0];
  assign valid    = (count != 2'd0);
  assign free_cnt = 2'(BUF_DEPTH) - count;
  // Head is forced to zero while empty so the output never shows stale data.
  assign head     = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + push_cnt - 2'(do_pop);
    end
  end

  // Storage writes; word 0 lands first in FIFO order, word 1 behind it.
  // NOTE: storage has no reset; occupancy alone decides what is valid, and head is masked when empty.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_cnt != 2'd0) mem[wr_ptr]  <= push_data0;
      if (push_cnt == 2'd2) mem[~wr_ptr] <= push_data1;
    end
  end

endmodule

// File: rtl/i2s_rx_dsp_channel.sv
// DSP/TDM-mode I2S receiver: frame-sync tracking, bit offset skip,
// one- or two-line deserialisation and hand-off to the RX FIFO.
module i2s_rx_dsp_channel
  import i2s_pkg::*;
(
  input  logic                          sck_i,
  input  logic                          rst_i,
  input  logic                          i2s_ch0_i,
  input  logic                          i2s_ch1_i,
  input  logic                          i2s_ws_i,
  i2s_rx_dsp_channel_if.master          fifo,
  input  logic                          cfg_en_i,
  input  logic                          cfg_2ch_i,
  input  logic [4:0]                    cfg_num_bits_i,
  input  logic [3:0]                    cfg_num_word_i,
  input  logic                          cfg_lsb_first_i,
  input  logic [8:0]                    cfg_dsp_offset_i
);

  i2s_state_e        state_q, state_d;
  logic [8:0]        offset_cnt_q;
  logic [4:0]        bit_cnt_q;
  logic [3:0]        word_cnt_q;
  logic [DATA_W-1:0] ch0_q, ch1_q;
  logic [DATA_W-1:0] ch0_word, ch1_word;
  logic              err_q;

  logic              fs_seen, last_bit, word_done, frame_done;
  logic [4:0]        bit_start;
  logic [1:0]        need, avail, free_cnt, push_cnt;
  logic              pop, fits;
  i2s_state_e        fs_target;

  assign bit_start  = cfg_lsb_first_i ? 5'd0 : cfg_num_bits_i;
  assign last_bit   = cfg_lsb_first_i ? (bit_cnt_q == cfg_num_bits_i) : (bit_cnt_q == 5'd0);
  assign fs_seen    = i2s_ws_i && (state_q != IDLE);
  assign fs_target  = (cfg_dsp_offset_i != 9'd0) ? OFFSET : RUN;
  assign word_done  = (state_q == RUN) && !i2s_ws_i && last_bit;
  assign frame_done = word_done && (word_cnt_q == cfg_num_word_i);

  assign pop      = fifo.fifo_data_valid && fifo.fifo_data_ready;
  assign need     = cfg_2ch_i ? 2'd2 : 2'd1;
  assign avail    = free_cnt + 2'(pop);
  assign fits     = (avail >= need);
  assign push_cnt = (word_done && fits && cfg_en_i) ? need : 2'd0;

  // Current words with this cycle's bit merged in at its index.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ch0_word = ch0_q;
    ch1_word = ch1_q;
    ch0_word[bit_cnt_q] = i2s_ch0_i;
    ch1_word[bit_cnt_q] = i2s_ch1_i;
  end

  // FSM state register.
  always_ff @(posedge sck_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; ws in any active state restarts the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = WAIT_FS;
      WAIT_FS: if (i2s_ws_i) state_d = fs_target;
      OFFSET:  if (i2s_ws_i) state_d = fs_target;
               else if (offset_cnt_q == 9'd0) state_d = RUN;
      RUN:     if (i2s_ws_i) state_d = fs_target;
               else if (frame_done) state_d = WAIT_FS;
      default: state_d = IDLE;
    endcase
    if (!cfg_en_i) state_d = IDLE;
  end

  // Offset, bit and word counters plus the two shift registers.
  always_ff @(posedge sck_i) begin
    if (rst_i || !cfg_en_i) begin
      offset_cnt_q <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      ch0_q        <= '0;
      ch1_q        <= '0;
    end else if (fs_seen) begin
      offset_cnt_q <= cfg_dsp_offset_i - 9'd1;
      bit_cnt_q    <= bit_start;
      word_cnt_q   <= '0;
      ch0_q        <= '0;
      ch1_q        <= '0;
    end else if (state_q == OFFSET) begin
      if (offset_cnt_q != 9'd0) offset_cnt_q <= offset_cnt_q - 9'd1;
    end else if (state_q == RUN) begin
      if (word_done) begin
        bit_cnt_q  <= bit_start;
        word_cnt_q <= frame_done ? 4'd0 : word_cnt_q + 4'd1;
        ch0_q      <= '0;
        ch1_q      <= '0;
      end else begin
        bit_cnt_q <= cfg_lsb_first_i ? bit_cnt_q + 5'd1 : bit_cnt_q - 5'd1;
        ch0_q     <= ch0_word;
        ch1_q     <= ch1_word;
      end
    end
  end

  // One-cycle overflow pulse when a completion finds too little room.
  always_ff @(posedge sck_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= word_done && !fits && cfg_en_i;
  end

  assign fifo.fifo_err = err_q;

  i2s_rx_word_buffer u_buf (
    .clk        (sck_i),
    .rst        (rst_i),
    .clear      (!cfg_en_i),
    .push_cnt   (push_cnt),
    .push_data0 (ch0_word),
    .push_data1 (ch1_word),
    .pop        (pop),
    .head       (fifo.fifo_data),
    .valid      (fifo.fifo_data_valid),
    .free_cnt   (free_cnt)
  );

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Directed bench for the DSP-mode I2S receive channel.
module tb_i2s_rx_dsp_channel;
  import i2s_pkg::*;

  logic       sck = 1'b0;
  logic       rst = 1'b1;
  logic       ch0 = 1'b0, ch1 = 1'b0, ws = 1'b0;
  logic       en = 1'b0, two_ch = 1'b0, lsb = 1'b0;
  logic [4:0] num_bits = '0;
  logic [3:0] num_word = '0;
  logic [8:0] offset = '0;

  int passed = 0;
  int total  = 0;

  i2s_rx_dsp_channel_if fifo_if ();

  i2s_rx_dsp_channel dut (
    .sck_i            (sck),
    .rst_i            (rst),
    .i2s_ch0_i        (ch0),
    .i2s_ch1_i        (ch1),
    .i2s_ws_i         (ws),
    .fifo             (fifo_if),
    .cfg_en_i         (en),
    .cfg_2ch_i        (two_ch),
    .cfg_num_bits_i   (num_bits),
    .cfg_num_word_i   (num_word),
    .cfg_lsb_first_i  (lsb),
    .cfg_dsp_offset_i (offset)
  );

  always #5 sck = ~sck;

  typedef struct {
    bit          lsb;
    bit          two_ch;
    int          nb;
    int          off;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Apply one cycle of serial inputs, then sample just after the edge.
  task automatic step(input logic w, input logic d0, input logic d1);
    ws  = w;
    ch0 = d0;
    ch1 = d1;
    @(posedge sck);
    #1;
  endtask

  // Send serial positions [from, to) of a word in its configured bit order.
  task automatic send_range(input logic [31:0] w0, input logic [31:0] w1, input int nb,
                            input bit lsb_first, input int from, input int to);
    for (int p = from; p < to; p++) begin
      int idx;
      idx = lsb_first ? p : nb - p;
      step(1'b0, w0[idx], w1[idx]);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nb);
    send_range(w, 32'h0, nb, lsb, 0, nb + 1);
  endtask

  task automatic run_vec(input vec_t v);
    lsb      = v.lsb;
    two_ch   = v.two_ch;
    num_bits = 5'(v.nb);
    offset   = 9'(v.off);
    num_word = 4'd0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (v.off) step(1'b0, 1'b1, 1'b1);
    send_range(v.w0, v.w1, v.nb, v.lsb, 0, v.nb);
    check("vec_valid_before_last", 32'(fifo_if.fifo_data_valid), 32'd0);
    send_range(v.w0, v.w1, v.nb, v.lsb, v.nb, v.nb + 1);
    check("vec_valid_after_last", 32'(fifo_if.fifo_data_valid), 32'd1);
    check("vec_data_ch0", fifo_if.fifo_data, v.exp0);
    step(1'b0, 1'b0, 1'b0);
    if (v.two_ch) begin
      check("vec_data_ch1", fifo_if.fifo_data, v.exp1);
      step(1'b0, 1'b0, 1'b0);
    end
    check("vec_drained", 32'(fifo_if.fifo_data_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] frame_words [4];

    vecs[0] = '{1'b0, 1'b0, 7,  0, 32'h000000A5, 32'h0,        32'h000000A5, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 15, 3, 32'h00001234, 32'h0000BEEF, 32'h00001234, 32'h0000BEEF};
    vecs[2] = '{1'b0, 1'b1, 31, 1, 32'hDEADBEEF, 32'h01234567, 32'hDEADBEEF, 32'h01234567};
    vecs[3] = '{1'b1, 1'b0, 0,  0, 32'h00000001, 32'h0,        32'h00000001, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 11, 5, 32'hFFFFFABC, 32'h0,        32'h00000ABC, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4,  2, 32'h00000033, 32'h0,        32'h00000013, 32'h0};

    fifo_if.fifo_data_ready = 1'b1;

    // Reset state.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(fifo_if.fifo_data_valid), 32'd0);
    check("rst_data", fifo_if.fifo_data, 32'd0);
    check("rst_err", 32'(fifo_if.fifo_err), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    en  = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("enable_state", 32'(dut.state_q), 32'(WAIT_FS));

    // Single-word frames across bit orders, widths, offsets and line counts.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Four back-to-back 32-bit words in one frame.
    frame_words[0] = 32'h89ABCDEF;
    frame_words[1] = 32'h00000001;
    frame_words[2] = 32'hFFFFFFFF;
    frame_words[3] = 32'h7E5A0C31;
    lsb = 1'b0; two_ch = 1'b0; num_bits = 5'd31; num_word = 4'd3; offset = 9'd0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      send_word(frame_words[w], 31);
      check("multi_data", fifo_if.fifo_data, frame_words[w]);
    end
    check("multi_state_end", 32'(dut.state_q), 32'(WAIT_FS));
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      check("multi_outside_frame", 32'(fifo_if.fifo_data_valid), 32'd0);
    end

    // Overflow with ready held low.
    num_bits = 5'd7; num_word = 4'd2;
    fifo_if.fifo_data_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    send_word(32'h11, 7);
    check("ovf_word1", fifo_if.fifo_data, 32'h11);
    send_word(32'h22, 7);
    check("ovf_head_hold", fifo_if.fifo_data, 32'h11);
    check("ovf_no_err_yet", 32'(fifo_if.fifo_err), 32'd0);
    send_word(32'h33, 7);
    check("ovf_err_pulse", 32'(fifo_if.fifo_err), 32'd1);
    check("ovf_head_kept", fifo_if.fifo_data, 32'h11);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_err_one_cycle", 32'(fifo_if.fifo_err), 32'd0);
    fifo_if.fifo_data_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("ovf_second_word", fifo_if.fifo_data, 32'h22);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_third_lost", 32'(fifo_if.fifo_data_valid), 32'd0);

    // Frame restart in the middle of a word.
    num_bits = 5'd15; num_word = 4'd0;
    step(1'b1, 1'b0, 1'b0);
    send_range(32'hFFFF, 32'h0, 15, 1'b0, 0, 5);
    step(1'b1, 1'b1, 1'b1);
    check("restart_no_err", 32'(fifo_if.fifo_err), 32'd0);
    check("restart_no_valid", 32'(fifo_if.fifo_data_valid), 32'd0);
    send_word(32'h6C3A, 15);
    check("restart_data", fifo_if.fifo_data, 32'h00006C3A);
    check("restart_err_after", 32'(fifo_if.fifo_err), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Disable with two entries buffered, then re-enable.
    num_bits = 5'd7; num_word = 4'd1;
    fifo_if.fifo_data_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    send_word(32'h5A, 7);
    send_word(32'hC3, 7);
    check("dis_head_before", fifo_if.fifo_data, 32'h5A);
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("dis_valid", 32'(fifo_if.fifo_data_valid), 32'd0);
    check("dis_data", fifo_if.fifo_data, 32'd0);
    check("dis_state", 32'(dut.state_q), 32'(IDLE));
    num_word = 4'd0;
    en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(1)), 1'b0);
    check("reen_waits_ws", 32'(fifo_if.fifo_data_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    send_word(32'h3C, 7);
    check("reen_data", fifo_if.fifo_data, 32'h3C);
    fifo_if.fifo_data_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("reen_drained", 32'(fifo_if.fifo_data_valid), 32'd0);

    // Reset in the middle of RUN with a word buffered.
    num_word = 4'd1;
    fifo_if.fifo_data_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    send_word(32'h81, 7);
    check("rstrun_buffered", 32'(fifo_if.fifo_data_valid), 32'd1);
    send_range(32'hFF, 32'h0, 7, 1'b0, 0, 3);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("rstrun_valid", 32'(fifo_if.fifo_data_valid), 32'd0);
    check("rstrun_data", fifo_if.fifo_data, 32'd0);
    check("rstrun_err", 32'(fifo_if.fifo_err), 32'd0);
    check("rstrun_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
